// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with single-outstanding req/ack data bus
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   enabled                   one-cycle start pulse from the controller
//   instr_in, alu_result,     executed instruction, effective address / result,
//   store_data                and rs2 store value, latched on start
//   mem_read, mem_write,      load / store flags, access size (0 byte, 1 half,
//   mem_size, mem_unsigned    2 word) and zero-extend select for loads
//   mem_req, mem_we,          data-memory request, held stable until mem_ack
//   mem_addr, mem_wdata,
//   mem_wstrb
//   mem_ack, mem_rdata        one-cycle completion with read data in the same cycle
//   instr_out, data_out       latched instruction and result for the write stage
//   misaligned, bus_err       sticky status of the last operation
//   completed                 results valid; drops in the cycle a new start arrives

package mem_stage_pkg;
    typedef struct packed {
        logic [31:0] word;
        logic [4:0]  rd;
        logic        rd_we;
    } instr_t;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enabled,
    input  instr_t            instr_in,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output instr_t            instr_out,
    output logic [31:0]       data_out,
    output logic              misaligned,
    output logic              bus_err,
    output logic              completed
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [31:0] TMO = TIMEOUT;

    state_t            state_q, state_d;
    instr_t            instr_q, instr_d;
    logic [31:0]       alu_q, alu_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [31:0]       data_out_q, data_out_d;
    logic              misaligned_q, misaligned_d;
    logic              bus_err_q, bus_err_d;
    logic              done_q, done_d;
    logic [31:0]       cnt_q, cnt_d;

    logic              start;
    logic [1:0]        off;
    logic              mis_in;
    logic [31:0]       lane;
    logic [31:0]       load_val;

    // A start pulse arriving mid-access is a protocol violation and is dropped.
    assign start  = enabled && (state_q != ACCESS);
    assign off    = alu_result[1:0];
    // Size 3 is not a legal encoding; it is treated like a word access.
    assign mis_in = ((mem_size == 2'd1) && off[0]) ||
                    ((mem_size >= 2'd2) && (off != 2'd0));

    // Bring the addressed lane down to bit 0, then extend.
    assign lane = mem_rdata >> {alu_q[1:0], 3'b000};

    always_comb begin
        load_val = mem_rdata;
        case (size_q)
            2'd0:    load_val = uns_q ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'd1:    load_val = uns_q ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        alu_d        = alu_q;
        size_d       = size_q;
        uns_d        = uns_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        data_out_d   = data_out_q;
        misaligned_d = misaligned_q;
        bus_err_d    = bus_err_q;
        done_d       = done_q;
        cnt_d        = cnt_q;

        if (start) begin
            instr_d      = instr_in;
            alu_d        = alu_result;
            size_d       = mem_size;
            uns_d        = mem_unsigned;
            done_d       = 1'b0;
            misaligned_d = 1'b0;
            bus_err_d    = 1'b0;
            cnt_d        = 32'd0;
            if (!(mem_read || mem_write)) begin
                state_d    = DONE;
                done_d     = 1'b1;
                data_out_d = alu_result;
            end else if (mis_in) begin
                state_d      = DONE;
                done_d       = 1'b1;
                misaligned_d = 1'b1;
                data_out_d   = 32'd0;
            end else begin
                state_d    = ACCESS;
                mem_req_d  = 1'b1;
                mem_we_d   = mem_write;
                mem_addr_d = {alu_result[ADDR_W-1:2], 2'b00};
                if (mem_write) begin
                    case (mem_size)
                        2'd0: begin
                            mem_wstrb_d = 4'b0001 << off;
                            mem_wdata_d = store_data << {off, 3'b000};
                        end
                        2'd1: begin
                            mem_wstrb_d = 4'b0011 << off;
                            mem_wdata_d = store_data << {off, 3'b000};
                        end
                        default: begin
                            mem_wstrb_d = 4'b1111;
                            mem_wdata_d = store_data;
                        end
                    endcase
                end else begin
                    mem_wstrb_d = 4'b0000;
                    mem_wdata_d = 32'd0;
                end
            end
        end else if (state_q == ACCESS) begin
            if (mem_ack) begin
                state_d     = DONE;
                done_d      = 1'b1;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
                mem_wstrb_d = 4'b0000;
                data_out_d  = mem_we_q ? alu_q : load_val;
            end else if ((TMO != 32'd0) && ((cnt_q + 32'd1) >= TMO)) begin
                // This cycle is the TIMEOUT-th request cycle without an ack.
                state_d     = DONE;
                done_d      = 1'b1;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
                mem_wstrb_d = 4'b0000;
                bus_err_d   = 1'b1;
                data_out_d  = 32'd0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            instr_q      <= '0;
            alu_q        <= 32'd0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            mem_wstrb_q  <= 4'd0;
            data_out_q   <= 32'd0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            alu_q        <= alu_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            data_out_q   <= data_out_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign instr_out  = instr_q;
    assign data_out   = data_out_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;
    assign completed  = done_q && !enabled;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between execute and the register write stage.
- On an `enabled` pulse it latches the executed instruction, ALU result and store data.
- It performs at most one load or store over a single-outstanding req/ack data-memory bus.
- It presents the instruction plus result data (load-extended or ALU passthrough) to the write stage, and reports `completed`.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- TIMEOUT, 0, if nonzero: bus cycles to wait for `mem_ack` before aborting with `bus_err`; 0 disables.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- enabled  in  1  one-cycle start pulse from controller
- instr_in  in  instructions struct  decoded instruction from execute
- alu_result  in  32  effective address for load/store, else result
- store_data  in  32  rs2 value for stores
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- mem_size  in  2  0=byte, 1=half, 2=word
- mem_unsigned  in  1  zero-extend load (LBU/LHU)
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  ADDR_W  word-aligned bus address ({addr[ADDR_W-1:2],2'b00})
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte strobes
- mem_ack  in  1  one-cycle completion; `mem_rdata` valid same cycle
- mem_rdata  in  32  read word
- instr_out  out  instructions struct  latched instruction to write stage
- data_out  out  32  value for write stage
- misaligned  out  1  latched: last op was misaligned
- bus_err  out  1  latched: last op timed out
- completed  out  1  stage done and results valid

Behaviour:
- Reset (async, rst=1): state IDLE; `mem_req`, `mem_we`, `mem_wstrb`, `misaligned`, `bus_err`, `done` all 0; `mem_addr`, `mem_wdata`, `data_out` 0; `instr_out` all-zero; `completed` 0.
- `completed` = `done` & !`enabled`, so it drops combinationally in the start cycle.
- FSM states: IDLE, ACCESS, DONE.
- IDLE/DONE + `enabled`:
  - Latch all inputs and clear `done`, `misaligned`, `bus_err`.
  - Misaligned when half with addr[0]=1, or word with addr[1:0]≠0.
  - Misaligned, or neither load nor store: go to DONE next edge. `data_out` = `alu_result` for non-memory ops, 0 for misaligned; `misaligned` set accordingly; no bus activity.
  - Otherwise go to ACCESS and assert `mem_req` from the next cycle. `mem_we` = `mem_write`.
  - Store strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
  - Store data: `mem_wdata` = `store_data` shifted left by 8*addr[1:0] (byte/half); word unshifted.
  - Loads: `mem_wstrb` = 0.
- ACCESS:
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` held stable until `mem_ack`.
  - On `mem_ack`: deassert `mem_req` the next cycle, go to DONE.
  - Load result: select byte/half lane by addr[1:0], then sign- or zero-extend per `mem_unsigned`. Word is unchanged.
  - Load result registers into `data_out`. Store: `data_out` = `alu_result`.
  - TIMEOUT≠0: a counter increments each ACCESS cycle without ack. On reaching TIMEOUT: drop `mem_req`, set `bus_err`, `data_out` = 0, go to DONE.
- DONE: `done`=1. Outputs hold until the next `enabled`.
- Latency: non-memory/misaligned, `completed` 1 cycle after `enabled`. Memory, `completed` 1 cycle after the `mem_ack` edge. Minimum memory latency is 3 cycles (`enabled` -> req -> ack -> completed).
- `enabled` during ACCESS is a protocol violation: ignored, state unchanged.
- `mem_ack` outside ACCESS is ignored.
- Reset asserted mid-ACCESS: `mem_req` drops immediately (async); no output is retained.

Test Plan:
- Reset, then `enabled` with non-memory op, `alu_result`=0x1234 -> next cycle `completed`=1, `data_out`=0x1234, `mem_req` never high.
- LB, addr 0x103, `mem_rdata`=0x80FF_FF7F, ack after 2 wait cycles -> `mem_addr`=0x100, `mem_req` high 3 cycles, `data_out`=0xFFFF_FF80; same with LBU -> 0x0000_0080.
- SH, addr 0x202, `store_data`=0xAAAA_BEEF, immediate ack -> `mem_we`=1, `mem_wstrb`=4'b1100, `mem_wdata`=0xBEEF_xxxx (upper half 0xBEEF), `completed` on the 3rd cycle.
- LW, addr 0x101 -> `misaligned`=1, `data_out`=0, `completed` after 1 cycle, no `mem_req`.
- TIMEOUT=4, LW with no ack -> `mem_req` high exactly 4 cycles, `bus_err`=1, `completed`=1, `data_out`=0.
- `rst` pulsed mid-ACCESS -> `mem_req`=0 and `completed`=0 same cycle; a subsequent normal LW completes correctly.
